// File: rtl/dma_loopback_tester.sv
// Write/read-back self-test engine: writes a pattern block, reads it back, checks every beat,
// repeats for a programmable loop count and reports done/pass with a saturating error count.
module dma_loopback_tester #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 64,
    parameter int          SIZE_WIDTH = 16,
    parameter int          ERR_WIDTH  = 8,
    parameter int          GAP_CYCLES = 127,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [SIZE_WIDTH-1:0] cfg_size,
    input  logic [1:0]            cfg_mode,
    input  logic [7:0]            cfg_loops,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_cnt,
    output logic                  wreq_valid,
    input  logic                  wreq_ready,
    output logic [ADDR_WIDTH-1:0] wreq_addr,
    output logic [SIZE_WIDTH-1:0] wreq_size,
    output logic                  wdata_valid,
    input  logic                  wdata_ready,
    output logic                  wdata_last,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wresp_valid,
    input  logic [1:0]            wresp,
    output logic                  rreq_valid,
    input  logic                  rreq_ready,
    output logic [ADDR_WIDTH-1:0] rreq_addr,
    output logic [SIZE_WIDTH-1:0] rreq_size,
    input  logic                  rdata_valid,
    output logic                  rdata_ready,
    input  logic                  rdata_last,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rresp_valid,
    input  logic [1:0]            rresp
);

    localparam int                BPB_LOG   = $clog2(DATA_WIDTH / 8);
    localparam int                GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [3:0] {
        S_IDLE, S_WREQ, S_WDATA, S_WRESP, S_GAP, S_RREQ, S_RDATA, S_RRESP, S_FIN
    } state_t;

    state_t                state_q, state_d;
    logic                  start_q, start_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SIZE_WIDTH-1:0] beats_q, beats_d;
    logic [1:0]            mode_q, mode_d;
    logic [7:0]            loops_q, loops_d;
    logic [7:0]            k_q, k_d;
    logic [SIZE_WIDTH-1:0] i_q, i_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  gap_rd_q, gap_rd_d;
    logic                  rresp_seen_q, rresp_seen_d;
    logic [31:0]           wlfsr_q, wlfsr_d;
    logic [31:0]           clfsr_q, clfsr_d;
    logic [ERR_WIDTH-1:0]  err_q, err_d;
    logic                  pass_hold_q, pass_hold_d;

    logic                  err_inc, err_clr, err_set;
    logic                  is_last;
    logic [SIZE_WIDTH-1:0] cfg_beats;
    logic [DATA_WIDTH-1:0] wpat, cpat;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] gen_pat(
        input logic [1:0]            mode,
        input logic [SIZE_WIDTH-1:0] idx,
        input logic [7:0]            kk,
        input logic [ADDR_WIDTH-1:0] base,
        input logic [31:0]           lf
    );
        logic [DATA_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] a;
        inc = DATA_WIDTH'(idx) + DATA_WIDTH'(kk);
        a   = base + (ADDR_WIDTH'(idx) << BPB_LOG);
        case (mode)
            2'd0:    return inc;
            2'd1:    return {(DATA_WIDTH / 32){lf}};
            2'd2:    return ~inc;
            default: return DATA_WIDTH'(a);
        endcase
    endfunction

    // Write generator and read checker run from separate LFSRs so the check is independent.
    assign cfg_beats = cfg_size >> BPB_LOG;
    assign is_last   = (i_q == beats_q - SIZE_WIDTH'(1));
    assign wpat      = gen_pat(mode_q, i_q, k_q, addr_q, wlfsr_q);
    assign cpat      = gen_pat(mode_q, i_q, k_q, addr_q, clfsr_q);

    always_comb begin
        state_d      = state_q;
        start_d      = start;
        addr_d       = addr_q;
        beats_d      = beats_q;
        mode_d       = mode_q;
        loops_d      = loops_q;
        k_d          = k_q;
        i_d          = i_q;
        gap_d        = gap_q;
        gap_rd_d     = gap_rd_q;
        rresp_seen_d = rresp_seen_q;
        wlfsr_d      = wlfsr_q;
        clfsr_d      = clfsr_q;
        err_d        = err_q;
        pass_hold_d  = pass_hold_q;
        err_inc      = 1'b0;
        err_clr      = 1'b0;
        err_set      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !start_q) begin
                    addr_d      = cfg_addr;
                    beats_d     = cfg_beats;
                    mode_d      = cfg_mode;
                    loops_d     = (cfg_loops == 8'd0) ? 8'd1 : cfg_loops;
                    k_d         = 8'd0;
                    i_d         = '0;
                    wlfsr_d     = LFSR_SEED;
                    clfsr_d     = LFSR_SEED;
                    err_clr     = 1'b1;
                    pass_hold_d = 1'b0;
                    if (cfg_beats == '0) begin
                        err_set = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_WREQ;
                    end
                end
            end
            S_WREQ: begin
                if (wreq_ready) begin
                    i_d     = '0;
                    state_d = S_WDATA;
                end
            end
            S_WDATA: begin
                if (wdata_ready) begin
                    wlfsr_d = lfsr_next(wlfsr_q);
                    i_d     = i_q + SIZE_WIDTH'(1);
                    if (is_last) state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (wresp_valid) begin
                    err_inc  = (wresp != 2'b00);
                    gap_d    = '0;
                    gap_rd_d = 1'b1;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = gap_rd_q ? S_RREQ : S_WREQ;
                else gap_d = gap_q + GAP_W'(1);
            end
            S_RREQ: begin
                rresp_seen_d = 1'b0;
                if (rreq_ready) begin
                    i_d     = '0;
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (rdata_valid) begin
                    clfsr_d = lfsr_next(clfsr_q);
                    i_d     = i_q + SIZE_WIDTH'(1);
                    if ((rdata != cpat) || (rdata_last != is_last)) err_inc = 1'b1;
                    if (is_last) state_d = S_RRESP;
                end
                // The read response may overtake the final data beat.
                if (rresp_valid && !rresp_seen_q) begin
                    rresp_seen_d = 1'b1;
                    if (rresp != 2'b00) err_inc = 1'b1;
                end
            end
            S_RRESP: begin
                if (rresp_seen_q || rresp_valid) begin
                    if (!rresp_seen_q && (rresp != 2'b00)) err_inc = 1'b1;
                    rresp_seen_d = 1'b0;
                    if (({1'b0, k_q} + 9'd1) < {1'b0, loops_q}) begin
                        k_d      = k_q + 8'd1;
                        gap_d    = '0;
                        gap_rd_d = 1'b0;
                        state_d  = S_GAP;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                pass_hold_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (err_clr) err_d = err_set ? ERR_WIDTH'(1) : '0;
        else if (err_inc && (err_q != '1)) err_d = err_q + ERR_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            start_q      <= 1'b0;
            addr_q       <= '0;
            beats_q      <= '0;
            mode_q       <= 2'd0;
            loops_q      <= 8'd0;
            k_q          <= 8'd0;
            i_q          <= '0;
            gap_q        <= '0;
            gap_rd_q     <= 1'b0;
            rresp_seen_q <= 1'b0;
            wlfsr_q      <= LFSR_SEED;
            clfsr_q      <= LFSR_SEED;
            err_q        <= '0;
            pass_hold_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            addr_q       <= addr_d;
            beats_q      <= beats_d;
            mode_q       <= mode_d;
            loops_q      <= loops_d;
            k_q          <= k_d;
            i_q          <= i_d;
            gap_q        <= gap_d;
            gap_rd_q     <= gap_rd_d;
            rresp_seen_q <= rresp_seen_d;
            wlfsr_q      <= wlfsr_d;
            clfsr_q      <= clfsr_d;
            err_q        <= err_d;
            pass_hold_q  <= pass_hold_d;
        end
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done        = (state_q == S_FIN);
    assign pass        = ((state_q == S_FIN) || pass_hold_q) && (err_q == '0);
    assign err_cnt     = err_q;
    assign wreq_valid  = (state_q == S_WREQ);
    assign wreq_addr   = addr_q;
    assign wreq_size   = beats_q;
    assign wdata_valid = (state_q == S_WDATA);
    assign wdata_last  = (state_q == S_WDATA) && is_last;
    assign wdata       = (state_q == S_WDATA) ? wpat : '0;
    assign rreq_valid  = (state_q == S_RREQ);
    assign rreq_addr   = addr_q;
    assign rreq_size   = beats_q;
    assign rdata_ready = (state_q == S_RDATA);

endmodule

// File: tb/tb_dma_loopback_tester.sv
// Bench for dma_loopback_tester: a memory responder echoes written beats back with optional
// faults; expected patterns and error counts come from a behavioural model of the test rules.
module tb_dma_loopback_tester;

    localparam int          AW   = 32;
    localparam int          DW   = 64;
    localparam int          SW   = 16;
    localparam int          EW   = 8;
    localparam int          GAP  = 127;
    localparam logic [31:0] SEED = 32'hACE1_0001;
    localparam int          TMO  = 5000;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [SW-1:0] cfg_size = '0;
    logic [1:0]    cfg_mode = '0;
    logic [7:0]    cfg_loops = '0;
    logic          busy, done, pass;
    logic [EW-1:0] err_cnt;
    logic          wreq_valid, wreq_ready = 1'b0;
    logic [AW-1:0] wreq_addr;
    logic [SW-1:0] wreq_size;
    logic          wdata_valid, wdata_ready = 1'b0, wdata_last;
    logic [DW-1:0] wdata;
    logic          wresp_valid = 1'b0;
    logic [1:0]    wresp = 2'd0;
    logic          rreq_valid, rreq_ready = 1'b0;
    logic [AW-1:0] rreq_addr;
    logic [SW-1:0] rreq_size;
    logic          rdata_valid = 1'b0, rdata_ready, rdata_last = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          rresp_valid = 1'b0;
    logic [1:0]    rresp = 2'd0;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem[0:511];

    dma_loopback_tester dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cfg_addr(cfg_addr), .cfg_size(cfg_size), .cfg_mode(cfg_mode), .cfg_loops(cfg_loops),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .wreq_addr(wreq_addr), .wreq_size(wreq_size),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata_last(wdata_last), .wdata(wdata),
        .wresp_valid(wresp_valid), .wresp(wresp),
        .rreq_valid(rreq_valid), .rreq_ready(rreq_ready), .rreq_addr(rreq_addr), .rreq_size(rreq_size),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata_last(rdata_last), .rdata(rdata),
        .rresp_valid(rresp_valid), .rresp(rresp)
    );

    // Clock / reset: reset is driven from the stimulus block.
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        int          taps[4];
        logic [31:0] m;
        taps = '{32, 22, 2, 1};
        m = '0;
        foreach (taps[j]) m[taps[j]-1] = 1'b1;
        return s[0] ? ((s >> 1) ^ m) : (s >> 1);
    endfunction

    function automatic logic [63:0] model_pat(input logic [1:0] mode, input int i, input int k,
                                              input logic [31:0] base, input logic [31:0] lf);
        logic [63:0] inc;
        logic [31:0] a;
        inc = 64'(i + k);
        a   = base + 32'(i * 8);
        case (mode)
            2'd0:    return inc;
            2'd1:    return {lf, lf};
            2'd2:    return ~inc;
            default: return {32'h0, a};
        endcase
    endfunction

    function automatic logic pick_ready(input int rdy_mode, input int cyc);
        if (rdy_mode == 1) return cyc[0];
        if (rdy_mode == 2) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Drives one complete test as the memory side. corrupt_beat: -1 none, -2 all beats.
    // flip_beat inverts rdata_last on that beat. abort_beat asserts rstn on that read beat.
    task automatic run_test(input logic [31:0] addr, input logic [15:0] size, input logic [1:0] mode,
                            input logic [7:0] loops, input int rdy_mode, input int corrupt_beat,
                            input int flip_beat, input logic [1:0] wresp_v, input logic [1:0] rresp_v,
                            input int rresp_early, input int abort_beat);
        int          beats, nloops, exp_err, n, t, gap;
        logic [31:0] lf;
        logic [63:0] e;
        logic        bad, ev, v;
        beats   = int'(size) / 8;
        nloops  = (loops == 8'd0) ? 1 : int'(loops);
        exp_err = 0;
        lf      = SEED;
        exp_q.delete();

        @(negedge clk);
        cfg_addr = addr; cfg_size = size; cfg_mode = mode; cfg_loops = loops;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Inputs wander mid-test; the engine must keep the latched configuration.
        cfg_addr = $urandom; cfg_size = 16'($urandom); cfg_mode = 2'($urandom); cfg_loops = 8'($urandom);

        if (beats == 0) begin
            check_eq("zero_done", done, 1'b1);
            check_eq("zero_busy", busy, 1'b0);
            check_eq("zero_err", err_cnt, 8'd1);
            check_eq("zero_pass", pass, 1'b0);
            for (int c = 0; c < 4; c++) begin
                check_eq("zero_noreq", {wreq_valid, rreq_valid, wdata_valid}, 3'b000);
                @(negedge clk);
            end
            return;
        end

        check_eq("start_busy", busy, 1'b1);
        check_eq("start_err_clr", err_cnt, 8'd0);
        check_eq("start_pass_clr", pass, 1'b0);

        for (int k = 0; k < nloops; k++) begin
            t = 0;
            gap = 0;
            while (!wreq_valid && t < TMO) begin
                if (gap == 5) start = 1'b1;
                if (gap == 6) start = 1'b0;
                @(negedge clk); t++; gap++;
            end
            if (t >= TMO) begin check_eq("tmo_wreq", 0, 1); return; end
            if (k > 0) check_eq("gap_loop", gap, GAP);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check_eq("wreq_hold", wreq_valid, 1'b1);
            check_eq("wreq_addr", wreq_addr, addr);
            check_eq("wreq_size", wreq_size, beats);
            wreq_ready = 1'b1;
            @(negedge clk);
            wreq_ready = 1'b0;

            for (int i = 0; i < beats; i++) begin
                exp_q.push_back(model_pat(mode, i, k, addr, lf));
                lf = lfsr_step(lf);
            end
            check_eq("wvalid_rise", wdata_valid, 1'b1);
            n = 0; t = 0;
            while (n < beats && t < TMO) begin
                wdata_ready = pick_ready(rdy_mode, t);
                if (wdata_valid && wdata_ready) begin
                    e = exp_q.pop_front();
                    check_eq("wdata", wdata, e);
                    check_eq("wlast", wdata_last, n == beats - 1);
                    mem[n] = wdata;
                    n++;
                end
                @(negedge clk); t++;
            end
            wdata_ready = 1'b0;
            if (n < beats) begin check_eq("tmo_wdata", n, beats); return; end
            check_eq("wvalid_fall", wdata_valid, 1'b0);

            wresp_valid = 1'b1; wresp = wresp_v;
            @(negedge clk);
            wresp_valid = 1'b0; wresp = 2'd0;
            if (wresp_v != 2'd0) exp_err++;

            t = 0;
            while (!rreq_valid && t < TMO) begin
                if (t == 5) start = 1'b1;
                if (t == 6) start = 1'b0;
                @(negedge clk); t++;
            end
            check_eq("gap_read", t, GAP);
            check_eq("gap_busy", busy, 1'b1);
            check_eq("rreq_addr", rreq_addr, addr);
            check_eq("rreq_size", rreq_size, beats);
            rreq_ready = 1'b1;
            @(negedge clk);
            rreq_ready = 1'b0;

            check_eq("rready", rdata_ready, 1'b1);
            n = 0; t = 0;
            while (n < beats && t < TMO) begin
                if (abort_beat == n) begin
                    check_eq("err_pre_abort", err_cnt, sat(exp_err));
                    rstn = 1'b0;
                    #1;
                    check_eq("rst_flags", {wreq_valid, wdata_valid, wdata_last, rreq_valid,
                                           rdata_ready, busy, done, pass}, 8'h00);
                    check_eq("rst_err", err_cnt, 8'd0);
                    check_eq("rst_addr", {wreq_addr, rreq_addr}, 64'd0);
                    check_eq("rst_size", {wreq_size, rreq_size}, 32'd0);
                    check_eq("rst_wdata", wdata, 64'd0);
                    rdata_valid = 1'b0; rdata_last = 1'b0;
                    @(negedge clk);
                    rstn = 1'b1;
                    return;
                end
                v = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                rdata_valid = v;
                if (v) begin
                    bad = (corrupt_beat == -2) || (corrupt_beat == n);
                    rdata = mem[n] ^ (bad ? 64'h1 : 64'h0);
                    rdata_last = (n == beats - 1) ^ (flip_beat == n);
                    ev = bad || (flip_beat == n);
                    if (rresp_early != 0 && n == beats - 1) begin
                        rresp_valid = 1'b1; rresp = rresp_v;
                        if (rresp_v != 2'd0) ev = 1'b1;
                    end
                    if (ev) exp_err++;
                    n++;
                end else begin
                    rdata = '0; rdata_last = 1'b0;
                end
                @(negedge clk); t++;
            end
            rdata_valid = 1'b0; rdata_last = 1'b0; rdata = '0;
            rresp_valid = 1'b0; rresp = 2'd0;
            if (n < beats) begin check_eq("tmo_rdata", n, beats); return; end
            if (rresp_early == 0) begin
                rresp_valid = 1'b1; rresp = rresp_v;
                @(negedge clk);
                rresp_valid = 1'b0; rresp = 2'd0;
                if (rresp_v != 2'd0) exp_err++;
            end else begin
                @(negedge clk);
            end
        end

        check_eq("done_pulse", done, 1'b1);
        check_eq("done_busy", busy, 1'b0);
        check_eq("err_cnt", err_cnt, sat(exp_err));
        check_eq("pass", pass, exp_err == 0);
        @(negedge clk);
        check_eq("done_fall", done, 1'b0);
        check_eq("pass_hold", pass, exp_err == 0);
        check_eq("exp_q_empty", exp_q.size(), 0);
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_flags", {wreq_valid, wdata_valid, wdata_last, rreq_valid, rdata_ready, busy, done, pass}, 8'h00);
        check_eq("reset_err", err_cnt, 8'd0);
        check_eq("reset_wdata", wdata, 64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        //        addr          size  mode loops rdy corrupt flip wresp rresp early abort
        run_test(32'h0000_1000, 16'd64,   2'd0, 8'd1, 0, -1, -1, 2'd0, 2'd0, 0, -1);
        run_test(32'h0000_1000, 16'd64,   2'd0, 8'd1, 0,  3, -1, 2'd0, 2'd0, 0, -1);
        run_test(32'h0000_2000, 16'd32,   2'd1, 8'd3, 1, -1, -1, 2'd0, 2'd0, 0, -1);
        run_test(32'h0000_1000, 16'd64,   2'd0, 8'd1, 0, -1, -1, 2'd2, 2'd2, 0, -1);
        run_test(32'h0000_1000, 16'd64,   2'd2, 8'd1, 0, -1,  5, 2'd0, 2'd0, 0, -1);
        run_test(32'h0000_1000, 16'd64,   2'd0, 8'd1, 0, -1,  7, 2'd0, 2'd0, 0, -1);
        run_test(32'h0000_1000, 16'd64,   2'd0, 8'd1, 0,  5,  5, 2'd0, 2'd0, 0, -1);
        run_test(32'h0000_3000, 16'd64,   2'd3, 8'd2, 0, -1, -1, 2'd0, 2'd0, 1, -1);
        run_test(32'h0000_3000, 16'd64,   2'd0, 8'd1, 0,  7, -1, 2'd0, 2'd2, 1, -1);
        run_test(32'h0000_1000, 16'd4,    2'd0, 8'd1, 0, -1, -1, 2'd0, 2'd0, 0, -1);
        run_test(32'h0000_1000, 16'd24,   2'd0, 8'd0, 0, -1, -1, 2'd0, 2'd0, 0, -1);
        run_test(32'h0000_4000, 16'd2400, 2'd0, 8'd1, 0, -2, -1, 2'd0, 2'd0, 0, -1);
        run_test(32'h0000_1000, 16'd64,   2'd0, 8'd1, 0, -2, -1, 2'd0, 2'd0, 0,  4);
        run_test(32'hFFFF_FFE0, 16'd64,   2'd3, 8'd1, 0, -1, -1, 2'd0, 2'd0, 0, -1);

        for (int r = 0; r < 5; r++) begin
            run_test($urandom, 16'($urandom_range(1, 16) * 8), 2'($urandom_range(0, 3)),
                     8'($urandom_range(0, 2)), 2, -1, -1, 2'd0, 2'd0, 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
